io_resp_merge64: RTL and testbench

IO_RESP_MERGE64 -- requirements
Module: io_resp_merge64

---
 rtl/io_resp_merge64.sv | 130 +++++++++++++
 tb/tb_io_resp_merge64.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/io_resp_merge64.sv
// Response merge for the 128-to-64 I/O bridge: buffers per-device 64-bit
// responses in small FIFOs and forwards them one per clock, round-robin.

package fta_bus_pkg;
  typedef struct packed {
    logic        ack;
    logic        err;
    logic        rty;
    logic        next;
    logic        stall;
    logic [63:0] dat;
    logic [7:0]  tid;
    logic [31:0] adr;
    logic [3:0]  pri;
  } fta_cmd_response64_t;
endpackage

module io_resp_merge64
  import fta_bus_pkg::*;
#(
  parameter int CHANNELS = 2,
  parameter int DEPTH    = 4
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  fta_cmd_response64_t [CHANNELS-1:0]  ch_resp,
  output fta_cmd_response64_t                 resp_o,
  output logic                                pending_o,
  output logic [CHANNELS-1:0]                 ovf_o
);

  localparam int PW = $clog2(DEPTH) + 1;
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  fta_cmd_response64_t mem [CHANNELS][DEPTH];
  logic [PW-1:0]       wptr [CHANNELS];
  logic [PW-1:0]       rptr [CHANNELS];
  logic [PW-1:0]       cnt  [CHANNELS];
  logic [CW-1:0]       rr_ptr;
  logic [CW-1:0]       gnt_idx;
  logic                gnt_vld;
  logic [CHANNELS-1:0] in_vld;
  logic [CHANNELS-1:0] not_empty;
  logic [CHANNELS-1:0] full;
  logic [CHANNELS-1:0] pop;
  logic [CHANNELS-1:0] push_ok;
  fta_cmd_response64_t head;

  // Pointers only ever count 0..DEPTH-1, so wrap explicitly.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Per-channel status: input valid, FIFO occupancy flags.
  always_comb begin
    for (int n = 0; n < CHANNELS; n++) begin
      in_vld[n]    = ch_resp[n].ack | ch_resp[n].err | ch_resp[n].rty;
      not_empty[n] = (cnt[n] != '0);
      full[n]      = (cnt[n] == PW'(DEPTH));
    end
  end

  // Round-robin search starting at rr_ptr, first non-empty FIFO wins.
  always_comb begin
    int c;
    c       = 0;
    gnt_vld = 1'b0;
    gnt_idx = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      c = (int'(rr_ptr) + i) % CHANNELS;
      if (!gnt_vld && not_empty[c]) begin
        gnt_vld = 1'b1;
        gnt_idx = CW'(c);
      end
    end
  end

  // A full FIFO still accepts a push when its head leaves in the same cycle.
  always_comb begin
    for (int n = 0; n < CHANNELS; n++) begin
      pop[n]     = gnt_vld && (gnt_idx == CW'(n));
      push_ok[n] = in_vld[n] && (!full[n] || pop[n]);
    end
    head = mem[gnt_idx][rptr[gnt_idx][AW-1:0]];
  end

  assign pending_o = |not_empty;

  // FIFO pointers, occupancy and sticky overflow flags.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int n = 0; n < CHANNELS; n++) begin
        wptr[n] <= '0;
        rptr[n] <= '0;
        cnt[n]  <= '0;
      end
      ovf_o <= '0;
    end else begin
      for (int n = 0; n < CHANNELS; n++) begin
        if (push_ok[n]) wptr[n] <= ptr_inc(wptr[n]);
        if (pop[n])     rptr[n] <= ptr_inc(rptr[n]);
        if (push_ok[n] && !pop[n])      cnt[n] <= cnt[n] + 1'b1;
        else if (!push_ok[n] && pop[n]) cnt[n] <= cnt[n] - 1'b1;
        if (in_vld[n] && full[n] && !pop[n]) ovf_o[n] <= 1'b1;
      end
    end
  end

  // FIFO storage; contents are don't-care until counted in.
  always_ff @(posedge clk_i) begin
    for (int n = 0; n < CHANNELS; n++) begin
      if (push_ok[n]) mem[n][wptr[n][AW-1:0]] <= ch_resp[n];
    end
  end

  // Registered merged output and round-robin pointer advance.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      resp_o <= '0;
      rr_ptr <= '0;
    end else begin
      resp_o <= gnt_vld ? head : '0;
      if (gnt_vld) begin
        rr_ptr <= (gnt_idx == CW'(CHANNELS - 1)) ? '0 : gnt_idx + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_io_resp_merge64.sv
// Directed bench for io_resp_merge64 with a per-channel scoreboard.
module tb_io_resp_merge64;
  import fta_bus_pkg::*;

  logic                      clk_i;
  logic                      rst_ni;
  fta_cmd_response64_t [1:0] ch_resp;
  fta_cmd_response64_t       resp_o;
  logic                      pending_o;
  logic [1:0]                ovf_o;

  int checks;
  int errors;
  int out_cnt;
  int base_cnt;
  fta_cmd_response64_t q0[$];
  fta_cmd_response64_t q1[$];

  io_resp_merge64 #(.CHANNELS(2), .DEPTH(4)) dut (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .ch_resp  (ch_resp),
    .resp_o   (resp_o),
    .pending_o(pending_o),
    .ovf_o    (ovf_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  function automatic fta_cmd_response64_t mk(input logic [7:0] tid, input logic [63:0] dat,
                                             input logic a, input logic e, input logic r);
    fta_cmd_response64_t x;
    x       = '0;
    x.ack   = a;
    x.err   = e;
    x.rty   = r;
    x.dat   = dat;
    x.tid   = tid;
    x.adr   = {24'hA50000, tid};
    x.pri   = tid[3:0];
    return x;
  endfunction

  function automatic logic [63:0] dpat(input logic [7:0] tid);
    return {8{tid}} ^ 64'h0123456789ABCDEF;
  endfunction

  task automatic chk_resp(input string tag, input fta_cmd_response64_t obs, input fta_cmd_response64_t exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Scoreboard: tid bit 7 names the source channel; order checked per channel.
  always @(negedge clk_i) begin
    fta_cmd_response64_t e;
    if (rst_ni && (resp_o.ack || resp_o.err || resp_o.rty)) begin
      out_cnt++;
      if (resp_o.tid[7]) begin
        chk_int("sb_ch1_expected", int'(q1.size() > 0), 1);
        if (q1.size() > 0) begin
          e = q1.pop_front();
          chk_resp("sb_ch1", resp_o, e);
        end
      end else begin
        chk_int("sb_ch0_expected", int'(q0.size() > 0), 1);
        if (q0.size() > 0) begin
          e = q0.pop_front();
          chk_resp("sb_ch0", resp_o, e);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input fta_cmd_response64_t r0, input fta_cmd_response64_t r1);
    ch_resp[0] = r0;
    ch_resp[1] = r1;
    step();
    ch_resp = '0;
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    #1;
    chk_resp("rst_resp", resp_o, '0);
    chk_int("rst_pending", int'(pending_o), 0);
    chk_int("rst_ovf", int'(ovf_o), 0);
    q0.delete();
    q1.delete();
    step();
    rst_ni = 1'b1;
  endtask

  initial begin
    fta_cmd_response64_t r0, r1, st;
    checks  = 0;
    errors  = 0;
    out_cnt = 0;
    rst_ni  = 1'b0;
    ch_resp = '0;
    #3;
    chk_resp("init_resp", resp_o, '0);
    chk_int("init_pending", int'(pending_o), 0);
    chk_int("init_ovf", int'(ovf_o), 0);
    step();
    step();
    rst_ni = 1'b1;

    // Single ack: two-clock latency, one-cycle output.
    r0 = mk(8'h05, 64'h1122334455667788, 1'b1, 1'b0, 1'b0);
    q0.push_back(r0);
    drive(r0, '0);
    chk_resp("t1_not_yet", resp_o, '0);
    chk_int("t1_pending", int'(pending_o), 1);
    step();
    chk_resp("t1_out", resp_o, r0);
    chk_int("t1_pending_clr", int'(pending_o), 0);
    step();
    chk_resp("t1_zero_after", resp_o, '0);

    // Simultaneous arrival, round-robin from 0, pointer returns to 0.
    do_reset();
    r0 = mk(8'h01, dpat(8'h01), 1'b1, 1'b0, 1'b0);
    r1 = mk(8'h81, dpat(8'h81), 1'b1, 1'b0, 1'b0);
    q0.push_back(r0);
    q1.push_back(r1);
    drive(r0, r1);
    chk_resp("t2_not_yet", resp_o, '0);
    step();
    chk_int("t2_first_ch0", int'(resp_o.tid), 8'h01);
    step();
    chk_int("t2_second_ch1", int'(resp_o.tid), 8'h81);
    step();
    chk_resp("t2_idle", resp_o, '0);
    r0 = mk(8'h02, dpat(8'h02), 1'b1, 1'b0, 1'b0);
    r1 = mk(8'h82, dpat(8'h82), 1'b1, 1'b0, 1'b0);
    q0.push_back(r0);
    q1.push_back(r1);
    drive(r0, r1);
    step();
    chk_int("t2_rr_back_at_0", int'(resp_o.tid), 8'h02);
    step();
    chk_int("t2_then_ch1", int'(resp_o.tid), 8'h82);
    step();

    // ch1 streams 10 acks, ch0 joins from the 3rd; ch1 fills, push+pop at
    // full on the 9th, drops the 10th.
    do_reset();
    base_cnt = out_cnt;
    for (int k = 1; k <= 10; k++) begin
      r1 = mk(8'h80 | 8'(k), dpat(8'h80 | 8'(k)), 1'b1, 1'b0, 1'b0);
      r0 = (k >= 3) ? mk(8'(k), dpat(8'(k)), 1'b1, 1'b0, 1'b0) : '0;
      if (k < 10) q1.push_back(r1);
      if (k >= 3) q0.push_back(r0);
      drive(r0, r1);
      if (k == 9) chk_int("t3_full_pushpop_no_ovf", int'(ovf_o), 0);
    end
    chk_int("t3_ovf_ch1", int'(ovf_o), 2'b10);
    repeat (20) step();
    chk_int("t3_q0_drained", q0.size(), 0);
    chk_int("t3_q1_drained", q1.size(), 0);
    chk_int("t3_out_count", out_cnt - base_cnt, 17);
    chk_int("t3_ovf_sticky", int'(ovf_o), 2'b10);
    chk_int("t3_pending_idle", int'(pending_o), 0);

    // Reset with three entries buffered; nothing stale afterwards.
    do_reset();
    drive(mk(8'h21, dpat(8'h21), 1'b1, 1'b0, 1'b0), mk(8'hA1, dpat(8'hA1), 1'b1, 1'b0, 1'b0));
    drive(mk(8'h22, dpat(8'h22), 1'b1, 1'b0, 1'b0), mk(8'hA2, dpat(8'hA2), 1'b1, 1'b0, 1'b0));
    chk_int("t4_pending_before", int'(pending_o), 1);
    rst_ni = 1'b0;
    #1;
    chk_resp("t4_resp_zero_now", resp_o, '0);
    chk_int("t4_pending_zero_now", int'(pending_o), 0);
    q0.delete();
    q1.delete();
    base_cnt = out_cnt;
    ch_resp[0] = mk(8'h23, dpat(8'h23), 1'b1, 1'b0, 1'b0);
    step();
    step();
    ch_resp = '0;
    chk_int("t4_ignored_in_reset", int'(pending_o), 0);
    rst_ni = 1'b1;
    repeat (8) step();
    chk_int("t4_no_stale_out", out_cnt - base_cnt, 0);
    chk_int("t4_pending_after", int'(pending_o), 0);
    chk_int("t4_ovf_cleared", int'(ovf_o), 0);

    // err-only forwarded, stall-only ignored, rty-only forwarded.
    r0 = mk(8'h31, dpat(8'h31), 1'b0, 1'b1, 1'b0);
    q0.push_back(r0);
    drive(r0, '0);
    st = mk(8'h32, dpat(8'h32), 1'b0, 1'b0, 1'b0);
    st.stall = 1'b1;
    drive(st, '0);
    chk_resp("t5_err_fwd", resp_o, r0);
    chk_int("t5_err_ack0", int'(resp_o.ack), 0);
    step();
    chk_resp("t5_stall_dropped", resp_o, '0);
    chk_int("t5_pending", int'(pending_o), 0);
    r1 = mk(8'hB3, dpat(8'hB3), 1'b0, 1'b0, 1'b1);
    q1.push_back(r1);
    drive('0, r1);
    step();
    chk_resp("t5_rty_fwd", resp_o, r1);
    step();

    chk_int("end_q0_empty", q0.size(), 0);
    chk_int("end_q1_empty", q1.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
